// File: rtl/adc_param_ctrl.sv
// ADC-driven parameter controller: captures SPI frame words into shadow registers and
// commits them to the harmonic datapath only on sequencer sample boundaries.
module adc_param_ctrl #(
    parameter int unsigned DIV_BIT       = 9,
    parameter logic [15:0] MAX_FREQ_STEP = 16'd64,
    parameter logic [15:0] FREQ_MIN      = 16'd8,
    parameter logic [15:0] FREQ_MAX      = 16'd4000,
    parameter logic [23:0] STALE_CYCLES  = 24'd7200000,
    parameter logic [15:0] RESET_FREQ    = 16'd50,
    parameter logic [15:0] RESET_FSCALE  = 16'd120,
    parameter int unsigned RESET_HSCALE  = 270,
    parameter int unsigned RESET_INIT    = 511
) (
    input  logic               fpga_clock,
    input  logic               reset,
    input  logic               i_Data_Received,
    input  logic [15:0]        i_Data0,
    input  logic [15:0]        i_Data1,
    input  logic [15:0]        i_Data2,
    input  logic [15:0]        i_Data3,
    input  logic               i_Commit,
    output logic [15:0]        o_Frequency,
    output logic [15:0]        o_Freq_Scale,
    output logic [DIV_BIT-1:0] o_Harmonic_Scale,
    output logic [DIV_BIT-1:0] o_Scale_Initial,
    output logic               o_Update_Pending,
    output logic               o_Adc_Stale,
    output logic [7:0]         o_Frame_Count
);

    localparam logic [DIV_BIT-1:0] RST_HSCALE = DIV_BIT'(RESET_HSCALE);
    localparam logic [DIV_BIT-1:0] RST_INIT   = DIV_BIT'(RESET_INIT);
    localparam logic signed [16:0] STEP       = $signed({1'b0, MAX_FREQ_STEP});

    typedef enum logic [1:0] {IDLE, PENDING, SLEW} state_t;

    state_t               state_q, state_d;
    logic                 data_rx_q;
    logic                 capture;
    logic                 commit;
    logic [15:0]          shd_freq, shd_fscale;
    logic [DIV_BIT-1:0]   shd_hscale, shd_init;
    logic [15:0]          freq_clamped;
    logic [15:0]          freq_step;
    logic signed [16:0]   freq_diff;
    logic [23:0]          stale_cnt, stale_next;

    // Oversized scale words saturate rather than wrap
    function automatic logic [DIV_BIT-1:0] sat_scale(input logic [15:0] d);
        if (|d[15:DIV_BIT]) return '1;
        return d[DIV_BIT-1:0];
    endfunction

    assign capture = i_Data_Received & ~data_rx_q;

    always_comb begin
        freq_clamped = i_Data0;
        if (i_Data0 < FREQ_MIN)      freq_clamped = FREQ_MIN;
        else if (i_Data0 > FREQ_MAX) freq_clamped = FREQ_MAX;
    end

    // One bounded frequency step toward the shadow target
    assign freq_diff = $signed({1'b0, shd_freq}) - $signed({1'b0, o_Frequency});

    always_comb begin
        freq_step = shd_freq;
        if (freq_diff > STEP)       freq_step = o_Frequency + MAX_FREQ_STEP;
        else if (freq_diff < -STEP) freq_step = o_Frequency - MAX_FREQ_STEP;
    end

    always_ff @(posedge fpga_clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A capture always wins the next state; commit in IDLE is ignored
    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture) state_d = PENDING;
            end
            PENDING, SLEW: begin
                if (i_Commit) begin
                    commit  = 1'b1;
                    state_d = (freq_step == shd_freq) ? IDLE : SLEW;
                end
                if (capture) state_d = PENDING;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            data_rx_q     <= 1'b0;
            shd_freq      <= RESET_FREQ;
            shd_fscale    <= RESET_FSCALE;
            shd_hscale    <= RST_HSCALE;
            shd_init      <= RST_INIT;
            o_Frame_Count <= 8'd0;
        end else begin
            data_rx_q <= i_Data_Received;
            if (capture) begin
                shd_freq      <= freq_clamped;
                shd_fscale    <= i_Data3;
                shd_hscale    <= sat_scale(i_Data1);
                shd_init      <= sat_scale(i_Data2);
                o_Frame_Count <= o_Frame_Count + 8'd1;
            end
        end
    end

    // Active parameters move only on a commit; the commit reads the pre-capture shadow
    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            o_Frequency      <= RESET_FREQ;
            o_Freq_Scale     <= RESET_FSCALE;
            o_Harmonic_Scale <= RST_HSCALE;
            o_Scale_Initial  <= RST_INIT;
            o_Update_Pending <= 1'b0;
        end else begin
            o_Update_Pending <= (state_d != IDLE);
            if (commit) begin
                o_Frequency      <= freq_step;
                o_Freq_Scale     <= shd_fscale;
                o_Harmonic_Scale <= shd_hscale;
                o_Scale_Initial  <= shd_init;
            end
        end
    end

    always_comb begin
        if (capture)                        stale_next = 24'd0;
        else if (stale_cnt == STALE_CYCLES) stale_next = stale_cnt;
        else                                stale_next = stale_cnt + 24'd1;
    end

    always_ff @(posedge fpga_clock) begin
        if (reset) begin
            stale_cnt   <= 24'd0;
            o_Adc_Stale <= 1'b0;
        end else begin
            stale_cnt   <= stale_next;
            o_Adc_Stale <= (stale_next == STALE_CYCLES);
        end
    end

endmodule

// File: tb/tb_adc_param_ctrl.sv
// Scoreboard bench for adc_param_ctrl: expected parameter sets are queued at commit time
// and compared one cycle later when the registered outputs update.
module tb_adc_param_ctrl;

    localparam int unsigned DIV_BIT = 9;
    localparam int          STEP    = 64;

    logic              fpga_clock = 1'b0;
    logic              reset;
    logic              i_Data_Received;
    logic [15:0]       i_Data0, i_Data1, i_Data2, i_Data3;
    logic              i_Commit;
    logic [15:0]       o_Frequency, o_Freq_Scale;
    logic [DIV_BIT-1:0] o_Harmonic_Scale, o_Scale_Initial;
    logic              o_Update_Pending, o_Adc_Stale;
    logic [7:0]        o_Frame_Count;

    adc_param_ctrl #(.STALE_CYCLES(24'd100)) dut (
        .fpga_clock      (fpga_clock),
        .reset           (reset),
        .i_Data_Received (i_Data_Received),
        .i_Data0         (i_Data0),
        .i_Data1         (i_Data1),
        .i_Data2         (i_Data2),
        .i_Data3         (i_Data3),
        .i_Commit        (i_Commit),
        .o_Frequency     (o_Frequency),
        .o_Freq_Scale    (o_Freq_Scale),
        .o_Harmonic_Scale(o_Harmonic_Scale),
        .o_Scale_Initial (o_Scale_Initial),
        .o_Update_Pending(o_Update_Pending),
        .o_Adc_Stale     (o_Adc_Stale),
        .o_Frame_Count   (o_Frame_Count)
    );

    always #5 fpga_clock = ~fpga_clock;

    typedef struct {
        logic [15:0] freq;
        logic [15:0] fscale;
        logic [8:0]  hscale;
        logic [8:0]  init;
        logic        pending;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [15:0] m_freq, m_fscale, s_freq, s_fscale;
    logic [8:0]  m_hscale, m_init, s_hscale, s_init;
    logic        m_busy;
    logic [7:0]  m_count;

    function automatic logic [8:0] sat9(input logic [15:0] d);
        if (d > 16'd511) return 9'd511;
        return d[8:0];
    endfunction

    function automatic logic [15:0] clampf(input logic [15:0] d);
        if (d < 16'd8) return 16'd8;
        if (d > 16'd4000) return 16'd4000;
        return d;
    endfunction

    function automatic logic [15:0] slew(input logic [15:0] cur, input logic [15:0] tgt);
        int d;
        d = int'(tgt) - int'(cur);
        if (d > STEP) return cur + 16'(STEP);
        if (d < -STEP) return cur - 16'(STEP);
        return tgt;
    endfunction

    task automatic tick();
        @(posedge fpga_clock);
        #1;
    endtask

    task automatic model_reset();
        m_freq = 16'd50; m_fscale = 16'd120; m_hscale = 9'd270; m_init = 9'd511;
        s_freq = 16'd50; s_fscale = 16'd120; s_hscale = 9'd270; s_init = 9'd511;
        m_busy = 1'b0; m_count = 8'd0;
    endtask

    task automatic model_capture(input logic [15:0] d0, d1, d2, d3);
        s_freq = clampf(d0); s_hscale = sat9(d1); s_init = sat9(d2); s_fscale = d3;
        m_busy = 1'b1;
        m_count = m_count + 8'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1; i_Data_Received = 1'b0; i_Commit = 1'b0;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic send_frame(input logic [15:0] d0, d1, d2, d3);
        i_Data0 = d0; i_Data1 = d1; i_Data2 = d2; i_Data3 = d3;
        i_Data_Received = 1'b1;
        model_capture(d0, d1, d2, d3);
        tick();
        checks++;
        if (o_Frame_Count !== m_count || o_Update_Pending !== 1'b1) begin
            errors++;
            $display("FAIL capture: count=%0d pend=%0b required count=%0d pend=1",
                     o_Frame_Count, o_Update_Pending, m_count);
        end
        i_Data_Received = 1'b0;
        tick();
    endtask

    // Commit pulse, optionally with a simultaneous new frame
    task automatic commit(input logic cap, input logic [15:0] d0, d1, d2, d3);
        exp_t e, g;
        checks++;
        if (o_Frequency !== m_freq || o_Freq_Scale !== m_fscale ||
            o_Harmonic_Scale !== m_hscale || o_Scale_Initial !== m_init) begin
            errors++;
            $display("FAIL pre_commit: freq=%0d fs=%0d hs=%0d in=%0d required %0d/%0d/%0d/%0d",
                     o_Frequency, o_Freq_Scale, o_Harmonic_Scale, o_Scale_Initial,
                     m_freq, m_fscale, m_hscale, m_init);
        end
        if (m_busy) begin
            m_freq = slew(m_freq, s_freq);
            m_fscale = s_fscale; m_hscale = s_hscale; m_init = s_init;
            m_busy = (m_freq != s_freq);
        end
        if (cap) model_capture(d0, d1, d2, d3);
        e.freq = m_freq; e.fscale = m_fscale; e.hscale = m_hscale; e.init = m_init;
        e.pending = m_busy;
        sb.push_back(e);
        i_Data0 = d0; i_Data1 = d1; i_Data2 = d2; i_Data3 = d3;
        i_Data_Received = cap;
        i_Commit = 1'b1;
        tick();
        i_Commit = 1'b0;
        i_Data_Received = 1'b0;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: queue empty, required one entry");
        end else begin
            g = sb.pop_front();
            if (o_Frequency !== g.freq || o_Freq_Scale !== g.fscale ||
                o_Harmonic_Scale !== g.hscale || o_Scale_Initial !== g.init ||
                o_Update_Pending !== g.pending || o_Frame_Count !== m_count) begin
                errors++;
                $display("FAIL commit: got %0d/%0d/%0d/%0d p=%0b c=%0d required %0d/%0d/%0d/%0d p=%0b c=%0d",
                         o_Frequency, o_Freq_Scale, o_Harmonic_Scale, o_Scale_Initial,
                         o_Update_Pending, o_Frame_Count, g.freq, g.fscale, g.hscale,
                         g.init, g.pending, m_count);
            end
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; i_Data_Received = 1'b0; i_Commit = 1'b0;
        i_Data0 = '0; i_Data1 = '0; i_Data2 = '0; i_Data3 = '0;
        tick(); tick();
        reset = 1'b0;
        model_reset();
        tick();
        checks++;
        if (o_Frequency !== 16'd50 || o_Freq_Scale !== 16'd120 || o_Harmonic_Scale !== 9'd270 ||
            o_Scale_Initial !== 9'd511 || o_Update_Pending !== 1'b0 || o_Frame_Count !== 8'd0 ||
            o_Adc_Stale !== 1'b0) begin
            errors++;
            $display("FAIL reset: got %0d/%0d/%0d/%0d p=%0b c=%0d s=%0b required 50/120/270/511 p=0 c=0 s=0",
                     o_Frequency, o_Freq_Scale, o_Harmonic_Scale, o_Scale_Initial,
                     o_Update_Pending, o_Frame_Count, o_Adc_Stale);
        end
    endtask

    task automatic test_basic_commit();
        send_frame(16'd100, 16'd300, 16'd400, 16'd200);
        repeat (3) tick();
        commit(1'b0, '0, '0, '0, '0);
        checks++;
        if (o_Frequency !== 16'd100 || o_Harmonic_Scale !== 9'd300 || o_Scale_Initial !== 9'd400 ||
            o_Freq_Scale !== 16'd200 || o_Update_Pending !== 1'b0) begin
            errors++;
            $display("FAIL basic: got %0d/%0d/%0d/%0d p=%0b required 100/200/300/400 p=0",
                     o_Frequency, o_Freq_Scale, o_Harmonic_Scale, o_Scale_Initial, o_Update_Pending);
        end
    endtask

    task automatic test_slew_and_clamp();
        send_frame(16'd1000, 16'd300, 16'd400, 16'd200);
        commit(1'b0, '0, '0, '0, '0);
        checks++;
        if (o_Frequency !== 16'd164) begin
            errors++;
            $display("FAIL slew_first: got %0d required 164", o_Frequency);
        end
        do_reset();
        send_frame(16'd1000, 16'd300, 16'd400, 16'd200);
        for (int k = 1; k <= 15; k++) begin
            commit(1'b0, '0, '0, '0, '0);
            if (k == 1 || k == 2 || k == 15) begin
                checks++;
                if (o_Frequency !== ((k == 1) ? 16'd114 : (k == 2) ? 16'd178 : 16'd1000) ||
                    o_Update_Pending !== (k != 15)) begin
                    errors++;
                    $display("FAIL slew_step%0d: got %0d p=%0b", k, o_Frequency, o_Update_Pending);
                end
            end
        end
        send_frame(16'd2, 16'h0400, 16'h0123, 16'd7);
        commit(1'b0, '0, '0, '0, '0);
        checks++;
        if (o_Frequency !== 16'd936 || o_Harmonic_Scale !== 9'd511 || o_Scale_Initial !== 9'd291) begin
            errors++;
            $display("FAIL clamp_sat: got %0d/%0d/%0d required 936/511/291",
                     o_Frequency, o_Harmonic_Scale, o_Scale_Initial);
        end
        for (int k = 0; k < 15; k++) commit(1'b0, '0, '0, '0, '0);
        checks++;
        if (o_Frequency !== 16'd8 || o_Update_Pending !== 1'b0) begin
            errors++;
            $display("FAIL clamp_min: got %0d p=%0b required 8 p=0", o_Frequency, o_Update_Pending);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        send_frame(16'd100, 16'd300, 16'd400, 16'd200);
        commit(1'b1, 16'd200, 16'd10, 16'd20, 16'd30);
        checks++;
        if (o_Frequency !== 16'd100 || o_Freq_Scale !== 16'd200 || o_Update_Pending !== 1'b1) begin
            errors++;
            $display("FAIL b2b_old: got %0d/%0d p=%0b required 100/200 p=1",
                     o_Frequency, o_Freq_Scale, o_Update_Pending);
        end
        commit(1'b0, '0, '0, '0, '0);
        checks++;
        if (o_Frequency !== 16'd164 || o_Harmonic_Scale !== 9'd10 || o_Freq_Scale !== 16'd30) begin
            errors++;
            $display("FAIL b2b_new: got %0d/%0d/%0d required 164/10/30",
                     o_Frequency, o_Harmonic_Scale, o_Freq_Scale);
        end
        commit(1'b0, '0, '0, '0, '0);
        // Capture with commit while idle: outputs hold, state goes pending
        commit(1'b1, 16'd300, 16'd1, 16'd2, 16'd3);
        commit(1'b0, '0, '0, '0, '0);
        // Level held high captures once
        i_Data0 = 16'd500; i_Data1 = 16'd5; i_Data2 = 16'd6; i_Data3 = 16'd9;
        i_Data_Received = 1'b1;
        model_capture(16'd500, 16'd5, 16'd6, 16'd9);
        repeat (10) tick();
        i_Data_Received = 1'b0;
        tick();
        checks++;
        if (o_Frame_Count !== m_count) begin
            errors++;
            $display("FAIL level_hold: count=%0d required %0d", o_Frame_Count, m_count);
        end
        commit(1'b0, '0, '0, '0, '0);
    endtask

    task automatic test_stale_and_wrap();
        do_reset();
        repeat (98) tick();
        tick();
        checks++;
        if (o_Adc_Stale !== 1'b0) begin
            errors++;
            $display("FAIL stale_early: got %0b at cycle 99 required 0", o_Adc_Stale);
        end
        tick();
        checks++;
        if (o_Adc_Stale !== 1'b1) begin
            errors++;
            $display("FAIL stale_rise: got %0b at cycle 100 required 1", o_Adc_Stale);
        end
        repeat (20) tick();
        checks++;
        if (o_Adc_Stale !== 1'b1 || o_Frequency !== 16'd50) begin
            errors++;
            $display("FAIL stale_hold: got %0b freq %0d required 1 freq 50", o_Adc_Stale, o_Frequency);
        end
        i_Data0 = 16'd60; i_Data1 = '0; i_Data2 = '0; i_Data3 = '0;
        i_Data_Received = 1'b1;
        model_capture(16'd60, '0, '0, '0);
        tick();
        checks++;
        if (o_Adc_Stale !== 1'b0) begin
            errors++;
            $display("FAIL stale_clear: got %0b required 0", o_Adc_Stale);
        end
        i_Data_Received = 1'b0;
        tick();
        for (int k = 0; k < 255; k++) send_frame(16'(k), 16'd1, 16'd2, 16'd3);
        checks++;
        if (o_Frame_Count !== 8'd0) begin
            errors++;
            $display("FAIL frame_wrap: count=%0d required 0", o_Frame_Count);
        end
    endtask

    task automatic test_reset_mid_slew();
        do_reset();
        send_frame(16'd1000, 16'd300, 16'd400, 16'd200);
        commit(1'b0, '0, '0, '0, '0);
        commit(1'b0, '0, '0, '0, '0);
        do_reset();
        checks++;
        if (o_Frequency !== 16'd50 || o_Update_Pending !== 1'b0 || o_Harmonic_Scale !== 9'd270) begin
            errors++;
            $display("FAIL reset_slew: got %0d p=%0b hs=%0d required 50 p=0 hs=270",
                     o_Frequency, o_Update_Pending, o_Harmonic_Scale);
        end
        commit(1'b0, '0, '0, '0, '0);
        checks++;
        if (o_Frequency !== 16'd50 || o_Freq_Scale !== 16'd120) begin
            errors++;
            $display("FAIL reset_discard: got %0d/%0d required 50/120", o_Frequency, o_Freq_Scale);
        end
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_slew_and_clamp();
        test_back_to_back();
        test_stale_and_wrap();
        test_reset_mid_slew();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
